// File: rtl/fc_requant_out.sv
// fc_requant_out: output stage for the FC processing-element array.
// Snapshots the PE accumulators when a tile completes and pulses a clear back
// to the PEs. Each lane is then processed in order: bias add, requant multiply,
// rounding right-shift, optional ReLU and int8 saturation. Results leave over
// a valid/ready stream toward the activation buffer.
module fc_requant_out #(
  parameter int NUM_PE  = 16,
  parameter int ACC_W   = 32,
  parameter int BIAS_W  = 32,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5,
  parameter int IDX_W   = $clog2(NUM_PE)
) (
  input  logic                            clk_i,
  input  logic                            rst_sync_i,
  input  logic                            start_i,
  input  logic [NUM_PE-1:0][ACC_W-1:0]    acc_i,
  input  logic                            relu_en_i,
  input  logic [MULT_W-1:0]               scale_mult_i,
  input  logic [SHIFT_W-1:0]              scale_shift_i,
  output logic [IDX_W-1:0]                bias_addr_o,
  input  logic signed [BIAS_W-1:0]        bias_i,
  output logic                            clear_acc_o,
  output logic                            busy_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic signed [7:0]               out_data_o,
  output logic [IDX_W-1:0]                out_idx_o,
  output logic                            out_last_o,
  output logic                            done_o
);

  // One extra bit over the wider operand so the bias add can never overflow.
  localparam int SUM_W  = ((ACC_W > BIAS_W) ? ACC_W : BIAS_W) + 1;
  // Full-precision product of the signed sum and the zero-extended multiplier.
  localparam int PROD_W = SUM_W + MULT_W + 1;
  // One more bit so adding the rounding constant cannot wrap.
  localparam int RND_W  = PROD_W + 1;

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_PE - 1);
  localparam logic signed [RND_W-1:0]  SAT_MAX  = RND_W'(127);
  localparam logic signed [RND_W-1:0]  SAT_MIN  = -(RND_W'(128));

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    BIAS,
    MUL,
    SHIFT,
    OUT,
    DONE
  } state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic signed [ACC_W-1:0]   snap [NUM_PE];
  logic                      relu_q;
  logic [MULT_W-1:0]         mult_q;
  logic [SHIFT_W-1:0]        shift_q;

  logic signed [SUM_W-1:0]   sum_p0;
  logic signed [PROD_W-1:0]  prod_p1;

  // Arithmetic right shift with round-half-up (toward +inf); shift 0 passes through.
  function automatic logic signed [RND_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] p,
    input logic [SHIFT_W-1:0]       sh
  );
    logic signed [RND_W-1:0] ext;
    logic signed [RND_W-1:0] half;
    ext = RND_W'(p);
    if (sh == '0) begin
      return ext;
    end
    half = RND_W'(1) <<< (sh - 1'b1);
    return (ext + half) >>> sh;
  endfunction

  // Optional ReLU followed by clamping to the int8 range.
  function automatic logic signed [7:0] relu_sat(
    input logic signed [RND_W-1:0] r,
    input logic                    relu
  );
    logic signed [RND_W-1:0] v;
    v = r;
    if (relu && v[RND_W-1]) begin
      v = '0;
    end
    if (v > SAT_MAX) begin
      return 8'h7F;
    end
    if (v < SAT_MIN) begin
      return 8'h80;
    end
    return v[7:0];
  endfunction

  // Datapath stages: bias add in BIAS, full-precision multiply in MUL.
  always_ff @(posedge clk_i) begin
    // stage p0: accumulator snapshot plus fetched bias
    if (state == BIAS) begin
      sum_p0 <= SUM_W'(snap[idx]) + SUM_W'(bias_i);
    end
    // stage p1: requant multiply, multiplier treated as non-negative
    if (state == MUL) begin
      prod_p1 <= PROD_W'(sum_p0) * PROD_W'($signed({1'b0, mult_q}));
    end
  end

  // Control FSM with registered outputs, snapshot capture and the result stage.
  always_ff @(posedge clk_i) begin
    if (rst_sync_i) begin
      state       <= IDLE;
      idx         <= '0;
      busy_o      <= 1'b0;
      clear_acc_o <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_idx_o   <= '0;
      out_last_o  <= 1'b0;
      done_o      <= 1'b0;
      bias_addr_o <= '0;
      relu_q      <= 1'b0;
      mult_q      <= '0;
      shift_q     <= '0;
      for (int i = 0; i < NUM_PE; i++) begin
        snap[i] <= '0;
      end
    end else begin
      clear_acc_o <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            for (int i = 0; i < NUM_PE; i++) begin
              snap[i] <= acc_i[i];
            end
            relu_q      <= relu_en_i;
            mult_q      <= scale_mult_i;
            shift_q     <= scale_shift_i;
            idx         <= '0;
            bias_addr_o <= '0;
            clear_acc_o <= 1'b1;
            busy_o      <= 1'b1;
            state       <= FETCH;
          end
        end
        // bias_addr_o already holds idx; memory answers during BIAS
        FETCH: state <= BIAS;
        BIAS:  state <= MUL;
        MUL:   state <= SHIFT;
        // stage p2: round, ReLU, saturate straight into the output register
        SHIFT: begin
          out_data_o  <= relu_sat(round_shift(prod_p1, shift_q), relu_q);
          out_idx_o   <= idx;
          out_last_o  <= (idx == LAST_IDX);
          out_valid_o <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            if (out_last_o) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              idx         <= idx + 1'b1;
              bias_addr_o <= idx + 1'b1;
              state       <= FETCH;
            end
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_requant_out.sv
// Testbench for fc_requant_out: table of single-tile vectors with a reference
// model and output scoreboard, plus sequences for backpressure, start while
// busy and mid-tile reset.
`timescale 1ns/1ps
module tb_fc_requant_out;

  localparam int NUM_PE = 16;
  localparam int IDX_W  = 4;

  logic                         clk = 1'b0;
  logic                         rst_sync_i;
  logic                         start_i;
  logic [NUM_PE-1:0][31:0]      acc_i;
  logic                         relu_en_i;
  logic [15:0]                  scale_mult_i;
  logic [4:0]                   scale_shift_i;
  logic [IDX_W-1:0]             bias_addr_o;
  logic signed [31:0]           bias_i;
  logic                         clear_acc_o;
  logic                         busy_o;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic signed [7:0]            out_data_o;
  logic [IDX_W-1:0]             out_idx_o;
  logic                         out_last_o;
  logic                         done_o;

  always #5 clk = ~clk;

  fc_requant_out #(
    .NUM_PE(NUM_PE), .ACC_W(32), .BIAS_W(32), .MULT_W(16), .SHIFT_W(5), .IDX_W(IDX_W)
  ) dut (
    .clk_i(clk), .rst_sync_i(rst_sync_i), .start_i(start_i), .acc_i(acc_i),
    .relu_en_i(relu_en_i), .scale_mult_i(scale_mult_i), .scale_shift_i(scale_shift_i),
    .bias_addr_o(bias_addr_o), .bias_i(bias_i), .clear_acc_o(clear_acc_o),
    .busy_o(busy_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_idx_o(out_idx_o), .out_last_o(out_last_o),
    .done_o(done_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bias memory with one cycle read latency.
  int acc_val  [NUM_PE];
  int bias_mem [NUM_PE];
  always @(posedge clk) bias_i <= bias_mem[bias_addr_o];

  // Reference requantization.
  function automatic int model(input int acc, input int bias, input int mult,
                               input int sh, input bit relu);
    longint s, p, r;
    s = longint'(acc) + longint'(bias);
    p = s * longint'(mult);
    if (sh == 0) r = p;
    else         r = (p + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    return int'(r);
  endfunction

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;
  exp_t sb[$];

  // Output monitor: scoreboard pops on transfer, stability check while stalled.
  bit      hold = 0;
  int      h_data, h_idx;
  bit      h_last;
  longint  last_xfer_t = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_sync_i) begin
      hold = 0;
    end else begin
      if (hold && out_valid_o) begin
        check("hold_data", out_data_o, h_data);
        check("hold_idx", out_idx_o, h_idx);
        check("hold_last", out_last_o, h_last);
      end
      hold   = out_valid_o && !out_ready_i;
      h_data = out_data_o;
      h_idx  = out_idx_o;
      h_last = out_last_o;
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", out_valid_o, 0);
        end else begin
          e = sb.pop_front();
          check($sformatf("data_lane%0d", e.idx), out_data_o, e.data);
          check("out_idx", out_idx_o, e.idx);
          check($sformatf("last_lane%0d", e.idx), out_last_o, e.last);
          if (out_last_o) last_xfer_t = $time;
        end
      end
    end
  end

  // Ready driver: 0 = always ready, 1 = stall lane 3 for 7 cycles, 2 = random.
  int bp_mode   = 0;
  int stall_cnt = 0;
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1: begin
          if (out_valid_o && out_idx_o == 3 && stall_cnt < 7) begin
            out_ready_i = 1'b0;
            stall_cnt++;
          end else begin
            out_ready_i = 1'b1;
          end
        end
        2:       out_ready_i = 1'($urandom_range(0, 1));
        default: out_ready_i = 1'b1;
      endcase
    end
  end

  task automatic fill_lanes(input int a0, input int b0);
    acc_val[0]  = a0;
    bias_mem[0] = b0;
    for (int l = 1; l < NUM_PE; l++) begin
      acc_val[l]  = int'($urandom_range(0, 2000000)) - 1000000;
      bias_mem[l] = int'($urandom_range(0, 2000)) - 1000;
    end
    for (int l = 0; l < NUM_PE; l++) acc_i[l] = acc_val[l];
  endtask

  // Called just after a posedge; returns just after the capturing edge.
  task automatic do_start(input bit relu, input int mult, input int sh,
                          input bit use_exp0, input int exp0);
    exp_t e;
    relu_en_i     = relu;
    scale_mult_i  = 16'(mult);
    scale_shift_i = 5'(sh);
    start_i       = 1'b1;
    for (int l = 0; l < NUM_PE; l++) begin
      e.data = (l == 0 && use_exp0) ? exp0
                                    : model(acc_val[l], bias_mem[l], mult, sh, relu);
      e.idx  = l;
      e.last = (l == NUM_PE - 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    // Scramble the latched controls to confirm they were captured at start.
    relu_en_i     = ~relu;
    scale_mult_i  = 16'($urandom);
    scale_shift_i = 5'($urandom);
  endtask

  task automatic wait_done(input int bound);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done_o && cyc < bound);
    check("done_seen", done_o, 1);
    check("busy_in_done", busy_o, 1);
    check("done_after_last", $time - last_xfer_t, 10);
    @(negedge clk);
    check("done_one_cycle", done_o, 0);
    check("busy_after_done", busy_o, 0);
    check("scoreboard_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int acc;
    int bias;
    int mult;
    int shift;
    bit relu;
    int bp;
    int exp;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int vcnt;
    vecs[0] = '{100,           -4,            3,     2,  1'b0, 1, 72};
    vecs[1] = '{-10,           0,             1,     2,  1'b0, 0, -2};
    vecs[2] = '{-10,           0,             1,     2,  1'b1, 2, 0};
    vecs[3] = '{100000,        0,             1,     0,  1'b0, 0, 127};
    vecs[4] = '{-100000,       0,             1,     0,  1'b0, 2, -128};
    vecs[5] = '{32'h7FFFFFFF,  127,           65535, 31, 1'b0, 0, 127};
    vecs[6] = '{32'h80000000,  32'h80000000,  65535, 31, 1'b0, 0, -128};
    vecs[7] = '{6,             0,             1,     2,  1'b0, 0, 2};
    vecs[8] = '{-6,            0,             1,     2,  1'b0, 2, -1};

    rst_sync_i    = 1'b1;
    start_i       = 1'b0;
    relu_en_i     = 1'b0;
    scale_mult_i  = '0;
    scale_shift_i = '0;
    acc_i         = '0;
    for (int l = 0; l < NUM_PE; l++) bias_mem[l] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_sync_i = 1'b0;
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_clear", clear_acc_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_idx", out_idx_o, 0);
    check("rst_last", out_last_o, 0);
    check("rst_done", done_o, 0);
    check("rst_addr", bias_addr_o, 0);
    @(posedge clk);
    #1;

    // Table-driven tiles.
    for (int v = 0; v < 9; v++) begin
      bp_mode   = vecs[v].bp;
      stall_cnt = 0;
      fill_lanes(vecs[v].acc, vecs[v].bias);
      do_start(vecs[v].relu, vecs[v].mult, vecs[v].shift, 1'b1, vecs[v].exp);
      if (v == 0) begin
        @(negedge clk);
        check("clear_at_n1", clear_acc_o, 1);
        check("busy_at_n1", busy_o, 1);
        for (int k = 2; k <= 5; k++) begin
          @(negedge clk);
          check($sformatf("clear_at_n%0d", k), clear_acc_o, 0);
          check($sformatf("valid_at_n%0d", k), out_valid_o, (k == 5) ? 1 : 0);
        end
        check("first_idx", out_idx_o, 0);
      end
      wait_done(400);
      if (v == 0) check("lane3_stall_cycles", stall_cnt, 7);
    end
    bp_mode = 0;

    // start_i while busy with changing acc_i: ignored.
    fill_lanes(12345, -345);
    do_start(1'b0, 5, 4, 1'b0, 0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      start_i = (k < 3);
      for (int l = 0; l < NUM_PE; l++) acc_i[l] = $urandom;
      @(negedge clk);
      check("clear_while_busy", clear_acc_o, 0);
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    wait_done(400);

    // Reset while lane 5 is in MUL.
    fill_lanes(-5000, 300);
    do_start(1'b0, 2, 1, 1'b0, 0);
    vcnt = 0;
    do begin
      @(negedge clk);
      vcnt++;
    end while (!(out_valid_o && out_idx_o == 4) && vcnt < 200);
    check("lane4_reached", out_idx_o, 4);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_sync_i = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst_sync_i = 1'b0;
    @(negedge clk);
    check("mrst_busy", busy_o, 0);
    check("mrst_clear", clear_acc_o, 0);
    check("mrst_valid", out_valid_o, 0);
    check("mrst_data", out_data_o, 0);
    check("mrst_idx", out_idx_o, 0);
    check("mrst_last", out_last_o, 0);
    check("mrst_done", done_o, 0);
    check("mrst_addr", bias_addr_o, 0);
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid_o || busy_o) vcnt++;
    end
    check("quiet_after_reset", vcnt, 0);
    @(posedge clk);
    #1;
    fill_lanes(100, -4);
    do_start(1'b0, 3, 2, 1'b1, 72);
    wait_done(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
